tmds_decoder: RTL and testbench
===============================

Name: tmds_decoder

Overview:
- Receive-side counterpart of the HDMI TMDS encoder.
- Takes raw 10-bit words from an external 1:10 deserializer in the pixel clock domain. Finds the symbol boundary by internal bit-slip, then decodes each symbol to 8-bit video data or a 2-bit control token.
- Used for HDMI loopback checking and bench self-test of the TMDS output path.

Parameters:
- LOCK_TOKENS, 8: consecutive control tokens at one offset required to declare lock.
- SEARCH_TIMEOUT, 2048: valid words with no control token before bit-slip advances while unlocked. Must exceed one 720p line (1650).
- LOSS_TIMEOUT, 2048: valid words with no control token before lock is dropped.

Ports:
- pixel_clk_in  in  1  pixel clock; all logic on rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- tmds_in  in  10  deserialized word; bit 0 is the first bit received on the wire.
- valid_in  in  1  tmds_in carries a new word this cycle.
- data_out  out  8  decoded video byte; meaningful when ve_out=1.
- control_out  out  2  decoded control bits {c1,c0}; meaningful when ve_out=0.
- ve_out  out  1  1 = data symbol, 0 = control token.
- valid_out  out  1  one-cycle qualifier for data_out, control_out and ve_out.
- locked_out  out  1  symbol alignment achieved.
- offset_out  out  4  current bit-slip offset, 0..9.

Behaviour:
- Reset (rst_in=0, asynchronous): every output 0. offset=0, locked=0, all counters 0, history register 0.
- Single clock domain; no CDC.
- Window formation:
  - On a valid_in cycle: cat = {tmds_in, prev} (20 bits), prev <= tmds_in.
  - win = cat[offset+9 : offset].
  - Stage 1 registers win plus a valid flag. valid_in=0 freezes prev, the counters and the FSM.
- Decode (stage 2, registered):
  - Control tokens, written as win[9:0]: 1101010100 -> 00; 0010101011 -> 01; 0101010100 -> 10; 1010101011 -> 11. On match: ve_out=0, control_out=token, data_out=0.
  - Otherwise ve_out=1, control_out=0. Compute d = win[9] ? ~win[7:0] : win[7:0]. Then data_out[0] = d[0], and for i = 1..7: data_out[i] = win[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- Latency: word presented with valid_in at edge N appears at outputs with valid_out=1 after edge N+2. valid_out mirrors valid_in delayed by 2; no backpressure.
- Token match for the FSM is evaluated on the stage-1 window.
- FSM states: SEARCH, LOCKED.
- SEARCH:
  - On a valid cycle, a control token increments tok_cnt (saturates at LOCK_TOKENS); a non-token clears tok_cnt.
  - tmo_cnt clears on a token and otherwise increments.
  - tok_cnt reaching LOCK_TOKENS -> LOCKED, locked_out=1, counters cleared.
  - tmo_cnt reaching SEARCH_TIMEOUT -> offset = (offset==9) ? 0 : offset+1, and both counters cleared. Offset wraps 9 -> 0.
  - If lock and timeout occur in the same cycle, lock wins and the offset is unchanged.
- LOCKED:
  - Offset held. tmo_cnt clears on any token and otherwise increments.
  - tmo_cnt reaching LOSS_TIMEOUT -> SEARCH, locked_out=0, counters cleared, offset advanced by one.
- Decoded outputs are produced regardless of lock state. Consumers must qualify them with locked_out.
- Reset asserted mid-operation returns everything to reset values immediately. Alignment restarts at offset 0.
- offset_out and locked_out are registered and update on the edge of the FSM transition.

Test Plan:
- Reset: hold rst_in=0 while toggling the clock with random tmds_in. Required: all outputs 0. Release: first valid_out two edges after the first valid_in.
- Aligned loopback:
  - Stimulus: encoder driven with 20 blanking cycles of control {vs,hs}=2'b10, then data bytes 8'h00, 8'hFF, 8'hA5, 8'h3C; words fed at offset 0.
  - Required: locked_out=1 after the 8th token, offset_out=0, control_out=2'b10 with ve_out=0, then data_out reproduces 00, FF, A5, 3C with ve_out=1, each two cycles after input.
- Bit-slip search:
  - Stimulus: the same stream delayed by 3 bits across word boundaries.
  - Required: offset_out steps 0 -> 1 -> 2 -> 3 at SEARCH_TIMEOUT intervals (stream includes 2048-word data runs). Lock at offset 3; bytes then decode correctly.
- Offset wrap: stream misaligned so the correct offset is 2, with the search starting after a forced climb past 9. Required: offset sequence …8, 9, 0, 1, 2, then lock.
- Loss of lock: after lock, feed 2048 consecutive data words with no control token. Required: locked_out falls on the 2048th word, offset_out increments by 1, FSM re-enters SEARCH.
- valid_in gaps: alternate valid_in 1/0 during the aligned loopback. Required: identical decoded sequence, valid_out pulses only for valid words, counters do not advance on idle cycles.

Source files
------------

// File: rtl/tmds_decoder.sv
// TMDS receive decoder: bit-slip alignment on control tokens, then per-symbol
// decode of 10-bit words into video bytes or 2-bit control tokens.
module tmds_decoder #(
  parameter int unsigned LOCK_TOKENS    = 8,
  parameter int unsigned SEARCH_TIMEOUT = 2048,
  parameter int unsigned LOSS_TIMEOUT   = 2048
) (
  input  logic       pixel_clk_in,
  input  logic       rst_in,
  input  logic [9:0] tmds_in,
  input  logic       valid_in,
  output logic [7:0] data_out,
  output logic [1:0] control_out,
  output logic       ve_out,
  output logic       valid_out,
  output logic       locked_out,
  output logic [3:0] offset_out
);

  localparam int unsigned TMO_MAX = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int unsigned TMO_W   = $clog2(TMO_MAX + 1);
  localparam int unsigned TOK_W   = $clog2(LOCK_TOKENS + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  // Returns {hit, code} for the four TMDS control tokens.
  function automatic logic [2:0] match_token(input logic [9:0] w);
    case (w)
      10'b1101010100: return 3'b100;
      10'b0010101011: return 3'b101;
      10'b0101010100: return 3'b110;
      10'b1010101011: return 3'b111;
      default:        return 3'b000;
    endcase
  endfunction

  logic [9:0]       prev;
  logic [19:0]      cat;
  logic [9:0]       win;
  logic [9:0]       win1;
  logic             v1;
  logic [2:0]       tok1;
  logic [7:0]       dinv;
  logic [7:0]       dec;
  state_t           state;
  logic [TOK_W-1:0] tok_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [TOK_W-1:0] tok_inc;
  logic [TMO_W-1:0] tmo_inc;
  logic [3:0]       offset_adv;

  // Window spans the previous and current word so any of the ten phases is reachable.
  always_comb begin
    cat = {tmds_in, prev};
    win = 10'(cat >> offset_out);
  end

  // Stage 1: history register and aligned window.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      prev <= '0;
      win1 <= '0;
      v1   <= 1'b0;
    end else begin
      v1 <= valid_in;
      if (valid_in) begin
        prev <= tmds_in;
        win1 <= win;
      end
    end
  end

  // Symbol decode on the stage-1 window: undo conditional inversion, then XOR/XNOR chain.
  always_comb begin
    tok1    = match_token(win1);
    dinv    = win1[9] ? ~win1[7:0] : win1[7:0];
    dec     = '0;
    dec[0]  = dinv[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = win1[8] ? (dinv[i] ^ dinv[i-1]) : ~(dinv[i] ^ dinv[i-1]);
    end
    tok_inc    = tok_cnt + TOK_W'(1);
    tmo_inc    = tmo_cnt + TMO_W'(1);
    offset_adv = (offset_out == 4'd9) ? 4'd0 : offset_out + 4'd1;
  end

  // Stage 2: registered decoded outputs.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_out   <= 1'b0;
      ve_out      <= 1'b0;
      control_out <= '0;
      data_out    <= '0;
    end else begin
      valid_out <= v1;
      if (v1) begin
        if (tok1[2]) begin
          ve_out      <= 1'b0;
          control_out <= tok1[1:0];
          data_out    <= '0;
        end else begin
          ve_out      <= 1'b1;
          control_out <= '0;
          data_out    <= dec;
        end
      end
    end
  end

  // Alignment FSM; advances only on valid stage-1 windows.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= SEARCH;
      tok_cnt    <= '0;
      tmo_cnt    <= '0;
      locked_out <= 1'b0;
      offset_out <= '0;
    end else if (v1) begin
      case (state)
        SEARCH: begin
          if (tok1[2]) begin
            tmo_cnt <= '0;
            if (tok_inc >= TOK_W'(LOCK_TOKENS)) begin
              state      <= LOCKED;
              locked_out <= 1'b1;
              tok_cnt    <= '0;
            end else begin
              tok_cnt <= tok_inc;
            end
          end else begin
            tok_cnt <= '0;
            if (tmo_inc >= TMO_W'(SEARCH_TIMEOUT)) begin
              tmo_cnt    <= '0;
              offset_out <= offset_adv;
            end else begin
              tmo_cnt <= tmo_inc;
            end
          end
        end
        LOCKED: begin
          if (tok1[2]) begin
            tmo_cnt <= '0;
          end else if (tmo_inc >= TMO_W'(LOSS_TIMEOUT)) begin
            state      <= SEARCH;
            locked_out <= 1'b0;
            tmo_cnt    <= '0;
            tok_cnt    <= '0;
            offset_out <= offset_adv;
          end else begin
            tmo_cnt <= tmo_inc;
          end
        end
        default: begin
          state <= SEARCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench: reference TMDS encoder feeds the decoder; a scoreboard
// queue holds the expected symbol for each valid word, popped when valid_out fires.
module tb_tmds_decoder;

  typedef struct packed {
    logic        en;
    logic [10:0] v;
  } exp_t;

  localparam logic [10:0] RAW_ZERO = {1'b1, 2'b00, 8'hFE};

  logic       clk;
  logic       rst_in;
  logic [9:0] tmds_in;
  logic       valid_in;
  logic [7:0] data_out;
  logic [1:0] control_out;
  logic       ve_out;
  logic       valid_out;
  logic       locked_out;
  logic [3:0] offset_out;

  int         n_chk;
  int         n_err;
  int         enc_cnt;
  exp_t       sb[$];
  logic [9:0] enc_q[$];
  logic [10:0] sym_q[$];
  exp_t       e_mon;

  tmds_decoder dut (
    .pixel_clk_in(clk),
    .rst_in      (rst_in),
    .tmds_in     (tmds_in),
    .valid_in    (valid_in),
    .data_out    (data_out),
    .control_out (control_out),
    .ve_out      (ve_out),
    .valid_out   (valid_out),
    .locked_out  (locked_out),
    .offset_out  (offset_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Scoreboard: pop one expectation per valid_out pulse.
  always @(negedge clk) begin
    if (rst_in && valid_out) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e_mon = sb.pop_front();
        if (e_mon.en) check("decode", 32'({ve_out, control_out, data_out}), 32'(e_mon.v));
      end
    end
  end

  function automatic logic [9:0] tok(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  // DVI reference encoder with running disparity.
  task automatic enc_data(input logic [7:0] d, output logic [9:0] q);
    int n1d, n1q, n0q;
    logic [8:0] qm;
    n1d   = $countones(d);
    qm    = '0;
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      enc_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt += (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_cnt += n1q - n0q - (qm[8] ? 0 : 2);
    end
  endtask

  task automatic add_ctl(input int n, input logic [1:0] c);
    for (int i = 0; i < n; i++) begin
      enc_q.push_back(tok(c));
      sym_q.push_back({1'b0, c, 8'h00});
    end
    enc_cnt = 0;
  endtask

  task automatic add_data(input int n, input logic [7:0] b);
    logic [9:0] q;
    for (int i = 0; i < n; i++) begin
      enc_data(b, q);
      enc_q.push_back(q);
      sym_q.push_back({1'b1, 2'b00, b});
    end
  endtask

  task automatic add_bytes();
    add_data(1, 8'h00);
    add_data(1, 8'hFF);
    add_data(1, 8'hA5);
    add_data(1, 8'h3C);
  endtask

  task automatic send(input logic [9:0] w, input logic v);
    tmds_in  = w;
    valid_in = v;
    @(posedge clk);
    #1;
  endtask

  // Drive stream word j delayed by d wire bits; the aligned window holds symbol j-1.
  task automatic send_idx(input int j, input int d, input bit en);
    logic [19:0] c;
    exp_t        e;
    c    = {enc_q[j], (j == 0) ? 10'd0 : enc_q[j-1]};
    e.en = en;
    e.v  = (j == 0) ? RAW_ZERO : sym_q[j-1];
    sb.push_back(e);
    send(10'(c >> (10 - d)), 1'b1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3; i++) send(10'd0, 1'b0);
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    #2;
    check("rst_async", 32'({data_out, control_out, ve_out, valid_out, locked_out, offset_out}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      send(10'($urandom), 1'b1);
      check("rst_hold", 32'({data_out, control_out, ve_out, valid_out, locked_out, offset_out}), 32'd0);
    end
    sb.delete();
    enc_q.delete();
    sym_q.delete();
    enc_cnt = 0;
    valid_in = 1'b0;
    @(negedge clk);
    rst_in = 1'b1;
  endtask

  // Data-only run forces n timeouts, then tokens lock at the final offset.
  task automatic slip_test(input int d, input int n);
    int t0;
    t0 = n * 2048 + 40;
    do_reset();
    add_data(t0, 8'h00);
    add_ctl(20, 2'b10);
    add_bytes();
    add_ctl(2, 2'b10);
    for (int j = 0; j < enc_q.size(); j++) begin
      send_idx(j, d, j >= n * 2048 + 4);
      if (j > 0 && j % 2048 == 0 && j <= n * 2048)
        check("slip_step", 32'(offset_out), 32'((j / 2048) % 10));
      if (j % 2048 == 2047 && j < n * 2048)
        check("slip_hold", 32'(offset_out), 32'((j / 2048) % 10));
      if (j == t0 + 8) check("slip_prelock", 32'(locked_out), 32'd0);
      if (j == t0 + 9) begin
        check("slip_lock", 32'(locked_out), 32'd1);
        check("slip_off", 32'(offset_out), 32'(d));
      end
    end
    drain("slip_drain");
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    enc_cnt  = 0;
    rst_in   = 1'b0;
    tmds_in  = '0;
    valid_in = 1'b0;

    // Aligned loopback followed by loss of lock.
    do_reset();
    add_ctl(20, 2'b10);
    add_bytes();
    add_data(2050, 8'h00);
    for (int j = 0; j < 2070; j++) begin
      send_idx(j, 0, 1'b1);
      if (j == 8) check("al_prelock", 32'(locked_out), 32'd0);
      if (j == 9) begin
        check("al_lock", 32'(locked_out), 32'd1);
        check("al_off", 32'(offset_out), 32'd0);
      end
      if (j == 2068) check("loss_hold", 32'(locked_out), 32'd1);
      if (j == 2069) begin
        check("loss_drop", 32'(locked_out), 32'd0);
        check("loss_off", 32'(offset_out), 32'd1);
      end
    end
    drain("al_drain");

    // Same stream with idle cycles between words; idle data must be ignored.
    do_reset();
    add_ctl(20, 2'b10);
    add_bytes();
    add_ctl(2, 2'b10);
    for (int j = 0; j < enc_q.size(); j++) begin
      send_idx(j, 0, 1'b1);
      if (j == 0) check("lat_early", 32'(valid_out), 32'd0);
      send(10'($urandom), 1'b0);
      if (j == 0) check("lat_first", 32'(valid_out), 32'd1);
      if (j == 7) check("gap_prelock", 32'(locked_out), 32'd0);
      if (j == 8) check("gap_lock", 32'(locked_out), 32'd1);
    end
    for (int i = 0; i < 3000; i++) send(10'($urandom), 1'b0);
    check("gap_idle_lock", 32'(locked_out), 32'd1);
    check("gap_drain", 32'(sb.size()), 32'd0);

    slip_test(3, 3);
    slip_test(2, 12);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
